pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max consecutive mem_busy cycles before fault (1..65535).
REQ-002 SHALL have parameter CNT_W, default 16, width of stall_count.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-low; sampled at posedge, asserted when 0.
REQ-005 id_rs  input  5  source register 1 of instruction in ID.
REQ-006 id_rt  input  5  source register 2 of instruction in ID.
REQ-007 id_uses_rt  input  1  ID instruction reads id_rt.
REQ-008 ex_memread  input  1  instruction in EX is a load.
REQ-009 ex_rt  input  5  destination register of the EX load.
REQ-010 branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-011 mem_busy  input  1  data memory cannot complete this cycle.
REQ-012 pc_hold  output  1  PC keeps its value.
REQ-013 hazard_hold  output  1  IF/ID register keeps Inst/Pc4.
REQ-014 ifid_flush  output  1  IF/ID register loads a nop.
REQ-015 idex_bubble  output  1  ID/EX register loads a nop.
REQ-016 pipe_freeze  output  1  EX/MEM and MEM/WB hold.
REQ-017 mem_fault  output  1  sticky memory-timeout flag.
REQ-018 stall_count  output  CNT_W  saturating count of pc_hold cycles.

Function
REQ-019 SHALL implement FSM states RUN, MEMWAIT, FAULT; state, wait counter, mem_fault, stall_count registered; control outputs combinational from state and current inputs.
REQ-020 load_use SHALL be ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
REQ-021 RUN, mem_busy=1: pc_hold=hazard_hold=pipe_freeze=1, flush/bubble=0; next state MEMWAIT, wait counter=1.
REQ-022 RUN, mem_busy=0, branch_taken=1: ifid_flush=idex_bubble=1, holds=0; load_use ignored; stay RUN.
REQ-023 RUN, mem_busy=0, branch_taken=0, load_use=1: pc_hold=hazard_hold=idex_bubble=1, ifid_flush=0, pipe_freeze=0; stay RUN (exactly one stall per load, since load advances to MEM).
REQ-024 RUN, none of above: all control outputs 0.
REQ-025 Priority SHALL be mem_busy > branch_taken > load_use; ifid_flush and hazard_hold never both 1.
REQ-026 MEMWAIT, mem_busy=1: pc_hold=hazard_hold=pipe_freeze=1; wait counter +1; when counter reaches MEM_TIMEOUT, next state FAULT, mem_fault=1 next cycle.
REQ-027 MEMWAIT, mem_busy=0: outputs evaluated as RUN (REQ-022..024) in same cycle; next state RUN; branch_taken/load_use held during wait SHALL therefore take effect on release cycle.
REQ-028 FAULT: pc_hold=hazard_hold=pipe_freeze=1, flush/bubble=0 every cycle regardless of inputs; exit only by reset.
REQ-029 stall_count SHALL increment each cycle pc_hold=1, saturating at all-ones, never wrapping.
REQ-030 Wait counter width SHALL be 16 bits; MEM_TIMEOUT busy cycles total (including RUN entry cycle) trigger FAULT.

Reset
REQ-031 reset=0 at posedge: state RUN, wait counter 0, mem_fault 0, stall_count 0; takes priority over all inputs incl. mid-MEMWAIT and FAULT.
REQ-032 While reset=0, combinational outputs SHALL follow RUN-state rules from current inputs; registered outputs read 0 the cycle after.

Verification
REQ-033 ex_memread=1, ex_rt=5, id_rs=5, others 0 -> one cycle pc_hold=hazard_hold=idex_bubble=1, stall_count 0->1.
REQ-034 ex_memread=1, ex_rt=0, id_rs=0 -> no stall; id_uses_rt=0, ex_rt=id_rt=7, id_rs=3 -> no stall.
REQ-035 branch_taken=1 with load_use=1 -> ifid_flush=idex_bubble=1, hazard_hold=0, stall_count unchanged.
REQ-036 mem_busy=1 for 3 cycles with branch_taken=1 held -> 3 frozen cycles, 4th cycle ifid_flush=1, stall_count=3.
REQ-037 MEM_TIMEOUT=4, mem_busy held high -> mem_fault=1 after 4th busy cycle, outputs frozen after mem_busy drops; reset=0 -> all cleared.
REQ-038 CNT_W=4, 20 stall cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / branch / memory-wait hazard controller for a 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_hold,
    output logic             hazard_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        FAULT   = 2'd2
    } state_t;

    localparam logic [15:0]      TIMEOUT = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic             mem_fault_q, mem_fault_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic   load_use;
    state_t eval_state;

    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // While reset is held the outputs already behave as in RUN, so the
    // pipeline sees a clean controller on the very first cycle out of reset.
    assign eval_state = reset ? state_q : RUN;

    always_comb begin
        pc_hold     = 1'b0;
        hazard_hold = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (eval_state == FAULT) begin
            pc_hold     = 1'b1;
            hazard_hold = 1'b1;
            pipe_freeze = 1'b1;
        end else if (mem_busy) begin
            pc_hold     = 1'b1;
            hazard_hold = 1'b1;
            pipe_freeze = 1'b1;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_hold     = 1'b1;
            hazard_hold = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_fault_d = mem_fault_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    wait_d = 16'd1;
                    if (TIMEOUT <= 16'd1) begin
                        state_d     = FAULT;
                        mem_fault_d = 1'b1;
                    end else begin
                        state_d = MEMWAIT;
                    end
                end else begin
                    wait_d = 16'd0;
                end
            end
            MEMWAIT: begin
                if (mem_busy) begin
                    wait_d = wait_q + 16'd1;
                    if (wait_d >= TIMEOUT) begin
                        state_d     = FAULT;
                        mem_fault_d = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                    wait_d  = 16'd0;
                end
            end
            FAULT: begin
                state_d     = FAULT;
                mem_fault_d = 1'b1;
            end
            default: begin
                state_d = RUN;
                wait_d  = 16'd0;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (pc_hold && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_q      <= 16'd0;
            mem_fault_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_fault_q <= mem_fault_d;
            stall_q     <= stall_d;
        end
    end

    assign mem_fault   = mem_fault_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CW      = 4;
    localparam int SAT     = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, ex_memread, branch_taken, mem_busy;
    logic          pc_hold, hazard_hold, ifid_flush, idex_bubble, pipe_freeze, mem_fault;
    logic [CW-1:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state: fault flag, consecutive busy cycles, stall total
    bit m_fault   = 1'b0;
    int m_busy_run = 0;
    int m_stall   = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_hold      (pc_hold),
        .hazard_hold  (hazard_hold),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .pipe_freeze  (pipe_freeze),
        .mem_fault    (mem_fault),
        .stall_count  (stall_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst_n, input bit busy, input bit br, input bit mr,
                        input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                        input bit uses);
        bit lu, frz, e_hold, e_hh, e_fl, e_bub, e_frz;
        @(negedge clock);
        reset = rst_n; mem_busy = busy; branch_taken = br; ex_memread = mr;
        ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = uses;
        #2;
        lu  = mr && (ert != 0) && ((ert == rs) || (uses && ert == rt));
        frz = rst_n && m_fault;
        e_frz  = frz || busy;
        e_hold = e_frz || (!br && lu);
        e_hh   = e_hold;
        e_fl   = !e_frz && br;
        e_bub  = !e_frz && (br || lu);
        chk("pc_hold",     32'(pc_hold),     32'(e_hold));
        chk("hazard_hold", 32'(hazard_hold), 32'(e_hh));
        chk("ifid_flush",  32'(ifid_flush),  32'(e_fl));
        chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        chk("pipe_freeze", 32'(pipe_freeze), 32'(e_frz));
        chk("mem_fault",   32'(mem_fault),   32'(m_fault));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
        if (!rst_n) begin
            m_fault = 1'b0; m_busy_run = 0; m_stall = 0;
        end else begin
            if (e_hold && m_stall < SAT) m_stall++;
            if (!m_fault) begin
                m_busy_run = busy ? m_busy_run + 1 : 0;
                if (m_busy_run >= TIMEOUT) m_fault = 1'b1;
            end
        end
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0; mem_busy = 0; branch_taken = 0; ex_memread = 0;
        ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;

        do_reset();
        after_edge();
        chk("rst_stall", 32'(stall_count), 32'd0);
        chk("rst_fault", 32'(mem_fault), 32'd0);

        step(1, 0, 0, 1, 5, 5, 0, 0);
        chk("lu_bubble", 32'(idex_bubble), 32'd1);
        after_edge();
        chk("lu_count", 32'(stall_count), 32'd1);

        step(1, 0, 0, 1, 0, 0, 0, 0);
        chk("r0_nostall", 32'(pc_hold), 32'd0);
        step(1, 0, 0, 1, 7, 3, 7, 0);
        chk("rt_unused_nostall", 32'(pc_hold), 32'd0);
        after_edge();
        chk("nostall_count", 32'(stall_count), 32'd1);

        step(1, 0, 1, 1, 5, 5, 0, 0);
        chk("br_flush", 32'(ifid_flush), 32'd1);
        chk("br_hh", 32'(hazard_hold), 32'd0);
        after_edge();
        chk("br_count", 32'(stall_count), 32'd1);

        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        chk("release_flush", 32'(ifid_flush), 32'd1);
        chk("release_count", 32'(stall_count), 32'd3);

        do_reset();
        for (int i = 0; i < TIMEOUT; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("timeout_fault", 32'(mem_fault), 32'd1);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        chk("fault_hold", 32'(pc_hold), 32'd1);
        chk("fault_noflush", 32'(ifid_flush), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("fault_cleared", 32'(mem_fault), 32'd0);
        chk("fault_cnt_cleared", 32'(stall_count), 32'd0);

        for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 9, 9, 0, 0);
        after_edge();
        chk("sat_count", 32'(stall_count), 32'(SAT));

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
